// File: rtl/dist_pkg.sv
// dist_pkg: shared definitions for the 1-to-3 beat distributor.
//   NUM_CH      number of output channels
//   SEL_*       in_sel encodings (11 is a legal alias for channel 2)
//   occ_e       occupancy state of a 2-entry channel FIFO
//   sel_to_ch() maps an in_sel code to a channel index
package dist_pkg;

   localparam int unsigned NUM_CH = 3;

   localparam logic [1:0] SEL_CH0  = 2'b00;
   localparam logic [1:0] SEL_CH1  = 2'b01;
   localparam logic [1:0] SEL_CH2  = 2'b10;
   localparam logic [1:0] SEL_CH2A = 2'b11;

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StTwo
   } occ_e;

   function automatic logic [1:0] sel_to_ch(input logic [1:0] sel);
      logic [1:0] ch;
      case (sel)
         SEL_CH0:  ch = 2'd0;
         SEL_CH1:  ch = 2'd1;
         SEL_CH2:  ch = 2'd2;
         SEL_CH2A: ch = 2'd2;
         default:  ch = 2'd2;
      endcase
      return ch;
   endfunction

endpackage

// File: rtl/demux_slot2.sv
// demux_slot2: 2-entry FIFO for one distributor channel.
//   clk, reset_l  clock and asynchronous active-low reset
//   push          write push_data (ignored when full and not popping)
//   push_data     beat to store
//   pop           consumer ready; advances the FIFO only when valid
//   valid         FIFO holds at least one beat
//   full          FIFO holds two beats
//   head_data     oldest beat; holds its last value when empty
module demux_slot2
   import dist_pkg::*;
#(
   parameter int unsigned DWIDTH = 2
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              push,
   input  logic [DWIDTH-1:0] push_data,
   input  logic              pop,
   output logic              valid,
   output logic              full,
   output logic [DWIDTH-1:0] head_data
);

   occ_e              occ_q, occ_d;
   logic [DWIDTH-1:0] head_q, head_d;
   logic [DWIDTH-1:0] tail_q, tail_d;
   logic              do_pop;
   logic              do_push;

   assign valid     = (occ_q != StEmpty);
   assign full      = (occ_q == StTwo);
   assign head_data = head_q;

   always_comb begin
      occ_d   = occ_q;
      head_d  = head_q;
      tail_d  = tail_q;
      do_pop  = pop & valid;
      do_push = push & (~full | do_pop);
      unique case (occ_q)
         StEmpty: begin
            if (do_push) begin
               head_d = push_data;
               occ_d  = StOne;
            end
         end
         StOne: begin
            if (do_push && do_pop) begin
               head_d = push_data;
            end else if (do_push) begin
               tail_d = push_data;
               occ_d  = StTwo;
            end else if (do_pop) begin
               // head_q keeps the stale beat; it is don't-care once empty
               occ_d = StEmpty;
            end
         end
         StTwo: begin
            if (do_pop) begin
               head_d = tail_q;
               if (do_push) begin
                  tail_d = push_data;
               end else begin
                  occ_d = StOne;
               end
            end
         end
         default: occ_d = StEmpty;
      endcase
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         occ_q  <= StEmpty;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         occ_q  <= occ_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

endmodule

// File: rtl/demux1to3_dist.sv
// demux1to3_dist: registered 1-to-3 distributor with a 2-entry FIFO and an
// accepted-beat counter per channel.
//   clk, reset_l             clock and asynchronous active-low reset
//   in_valid/in_ready        input handshake
//   in_sel                   destination (00 ch0, 01 ch1, 10/11 ch2)
//   in_data                  input payload
//   out_valid/out_ready      per-channel output handshake (bit i = channel i)
//   out_data0..2             per-channel head data
//   cnt_clr                  synchronous clear of all counters (beats a push)
//   cnt0..2                  beats accepted per channel, wrapping
module demux1to3_dist
   import dist_pkg::*;
#(
   parameter int unsigned DWIDTH = 2,
   parameter int unsigned CNTW   = 16
) (
   input  logic              clk,
   input  logic              reset_l,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [1:0]        in_sel,
   input  logic [DWIDTH-1:0] in_data,
   output logic [2:0]        out_valid,
   input  logic [2:0]        out_ready,
   output logic [DWIDTH-1:0] out_data0,
   output logic [DWIDTH-1:0] out_data1,
   output logic [DWIDTH-1:0] out_data2,
   input  logic              cnt_clr,
   output logic [CNTW-1:0]   cnt0,
   output logic [CNTW-1:0]   cnt1,
   output logic [CNTW-1:0]   cnt2
);

   logic [1:0]        dst;
   logic [2:0]        full;
   logic [2:0]        valid;
   logic [2:0]        push;
   logic              accept;
   logic [DWIDTH-1:0] head [NUM_CH];
   logic [CNTW-1:0]   cnt_q [NUM_CH];

   assign dst = sel_to_ch(in_sel);

   // Ready looks only at the addressed channel, so a stalled channel never
   // blocks traffic for the others. Gated by reset_l so nothing is accepted
   // while the FIFOs are held empty.
   assign in_ready = reset_l & (~full[dst] | (out_ready[dst] & valid[dst]));
   assign accept   = in_valid & in_ready;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign push[g] = accept & (dst == 2'(g));

      demux_slot2 #(
         .DWIDTH (DWIDTH)
      ) u_slot (
         .clk       (clk),
         .reset_l   (reset_l),
         .push      (push[g]),
         .push_data (in_data),
         .pop       (out_ready[g]),
         .valid     (valid[g]),
         .full      (full[g]),
         .head_data (head[g])
      );

      always_ff @(posedge clk or negedge reset_l) begin
         if (!reset_l) begin
            cnt_q[g] <= '0;
         end else if (cnt_clr) begin
            cnt_q[g] <= '0;
         end else if (push[g]) begin
            cnt_q[g] <= cnt_q[g] + 1'b1;
         end
      end
   end

   assign out_valid = valid;
   assign out_data0 = head[0];
   assign out_data1 = head[1];
   assign out_data2 = head[2];
   assign cnt0      = cnt_q[0];
   assign cnt1      = cnt_q[1];
   assign cnt2      = cnt_q[2];

endmodule

// File: tb/tb_demux1to3_dist.sv
// tb_demux1to3_dist: self-checking bench for demux1to3_dist. A queue per
// channel plus modular counters serve as the reference model.
module tb_demux1to3_dist;

   localparam int unsigned DW   = 2;
   localparam int unsigned CNTW = 4;

   logic            clk = 1'b0;
   logic            reset_l;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_sel;
   logic [DW-1:0]   in_data;
   logic [2:0]      out_valid;
   logic [2:0]      out_ready;
   logic [DW-1:0]   out_data0, out_data1, out_data2;
   logic            cnt_clr;
   logic [CNTW-1:0] cnt0, cnt1, cnt2;

   logic [DW-1:0]   od [3];
   logic [CNTW-1:0] cn [3];

   int passed = 0;
   int total  = 0;

   // Reference model
   logic [DW-1:0] mq [3][$];
   int            mcnt [3];

   always #5 clk = ~clk;

   assign od[0] = out_data0;
   assign od[1] = out_data1;
   assign od[2] = out_data2;
   assign cn[0] = cnt0;
   assign cn[1] = cnt1;
   assign cn[2] = cnt2;

   demux1to3_dist #(
      .DWIDTH (DW),
      .CNTW   (CNTW)
   ) dut (
      .clk       (clk),
      .reset_l   (reset_l),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .cnt_clr   (cnt_clr),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2)
   );

   function automatic int ch_of(input logic [1:0] s);
      return (s == 2'b11) ? 2 : int'(s);
   endfunction

   function automatic logic exp_ready(input logic [1:0] s, input logic [2:0] ordy);
      int d;
      d = ch_of(s);
      return (mq[d].size() < 2) || (ordy[d] && mq[d].size() > 0);
   endfunction

   function automatic logic [2:0] exp_valid();
      logic [2:0] v;
      for (int i = 0; i < 3; i++) v[i] = (mq[i].size() > 0);
      return v;
   endfunction

   function automatic logic [CNTW-1:0] exp_cnt(input int i);
      return CNTW'(mcnt[i]);
   endfunction

   // One clock: decide handshakes from current inputs, then apply at the edge.
   task automatic tick();
      logic [2:0] pops;
      logic       psh;
      int         d;
      for (int i = 0; i < 3; i++) pops[i] = out_ready[i] && (mq[i].size() > 0);
      d   = ch_of(in_sel);
      psh = in_valid && exp_ready(in_sel, out_ready);
      @(posedge clk);
      for (int i = 0; i < 3; i++) if (pops[i]) void'(mq[i].pop_front());
      if (psh) mq[d].push_back(in_data);
      if (cnt_clr) begin
         for (int i = 0; i < 3; i++) mcnt[i] = 0;
      end else if (psh) begin
         mcnt[d] = (mcnt[d] + 1) % (1 << CNTW);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_l   = 1'b0;
      in_valid  = 1'b0;
      in_sel    = 2'b00;
      in_data   = '0;
      out_ready = 3'b000;
      cnt_clr   = 1'b0;
      for (int i = 0; i < 3; i++) mcnt[i] = 0;
      #1;
      total++;
      if (out_valid !== 3'b000) $display("FAIL reset_valid got=%b want=000", out_valid);
      else passed++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         total++;
         if (od[i] !== '0 || cn[i] !== '0)
            $display("FAIL reset_ch%0d data=%b cnt=%0d want 0/0", i, od[i], cn[i]);
         else passed++;
      end
      @(negedge clk);
      @(negedge clk);
      reset_l = 1'b1;
   endtask

   task automatic test_basic();
      in_valid  = 1'b1;
      in_sel    = 2'b00;
      in_data   = 2'b01;
      out_ready = 3'b111;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL basic_ready got=%b want=1", in_ready);
      else passed++;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 3'b001) $display("FAIL basic_valid got=%b want=001", out_valid);
      else passed++;
      total++;
      if (out_data0 !== 2'b01) $display("FAIL basic_data0 got=%b want=01", out_data0);
      else passed++;
      total++;
      if (cnt0 !== 4'd1 || cnt1 !== 4'd0 || cnt2 !== 4'd0)
         $display("FAIL basic_cnt got=%0d/%0d/%0d want=1/0/0", cnt0, cnt1, cnt2);
      else passed++;
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 3'b000;
      in_valid  = 1'b1;
      in_sel    = 2'b01;
      in_data   = 2'b10;
      tick();
      in_data = 2'b11;
      tick();
      in_data = 2'b01;
      #1;
      total++;
      if (in_ready !== 1'b0) $display("FAIL bp_full_ready got=%b want=0", in_ready);
      else passed++;
      total++;
      if (out_valid !== 3'b010 || out_data1 !== 2'b10)
         $display("FAIL bp_head got valid=%b data=%b want 010/10", out_valid, out_data1);
      else passed++;
      out_ready = 3'b010;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL bp_pop_ready got=%b want=1", in_ready);
      else passed++;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_data1 !== 2'b11) $display("FAIL bp_seq2 got=%b want=11", out_data1);
      else passed++;
      tick();
      #1;
      total++;
      if (out_valid[1] !== 1'b1 || out_data1 !== 2'b01)
         $display("FAIL bp_seq3 got valid=%b data=%b want 1/01", out_valid[1], out_data1);
      else passed++;
      tick();
      #1;
      total++;
      if (out_valid !== 3'b000 || cnt1 !== 4'd3)
         $display("FAIL bp_end got valid=%b cnt1=%0d want 000/3", out_valid, cnt1);
      else passed++;
   endtask

   task automatic test_independence();
      out_ready = 3'b000;
      in_valid  = 1'b1;
      in_sel    = 2'b10;
      in_data   = 2'b11;
      tick();
      in_sel  = 2'b11;
      in_data = 2'b00;
      tick();
      in_sel  = 2'b00;
      in_data = 2'b10;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL indep_ch0_ready got=%b want=1", in_ready);
      else passed++;
      tick();
      in_sel  = 2'b11;
      in_data = 2'b01;
      #1;
      total++;
      if (out_valid !== exp_valid() || out_data0 !== 2'b10)
         $display("FAIL indep_valid got=%b/%b want=%b/10", out_valid, out_data0, exp_valid());
      else passed++;
      total++;
      if (in_ready !== 1'b0) $display("FAIL indep_ch2_block got=%b want=0", in_ready);
      else passed++;
      tick();
      out_ready = 3'b100;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL indep_ch2_pop_ready got=%b want=1", in_ready);
      else passed++;
      tick();
      in_valid  = 1'b0;
      out_ready = 3'b000;
      #1;
      total++;
      if (cnt2 !== exp_cnt(2) || out_data2 !== mq[2][0])
         $display("FAIL indep_cnt2 got=%0d/%b want=%0d/%b", cnt2, out_data2, exp_cnt(2),
                  mq[2][0]);
      else passed++;
      out_ready = 3'b111;
      repeat (3) tick();
   endtask

   task automatic test_wrap_clear();
      in_valid = 1'b0;
      cnt_clr  = 1'b1;
      tick();
      cnt_clr = 1'b0;
      #1;
      total++;
      if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || cnt2 !== 4'd0)
         $display("FAIL clr_idle got=%0d/%0d/%0d want=0/0/0", cnt0, cnt1, cnt2);
      else passed++;
      out_ready = 3'b111;
      in_valid  = 1'b1;
      in_sel    = 2'b01;
      for (int i = 0; i < 17; i++) begin
         in_data = DW'(i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      total++;
      if (cnt1 !== 4'd1) $display("FAIL wrap_cnt1 got=%0d want=1", cnt1);
      else passed++;
      in_valid = 1'b1;
      cnt_clr  = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
      #1;
      total++;
      if (cnt1 !== 4'd0 || out_valid !== exp_valid())
         $display("FAIL clr_wins got cnt1=%0d valid=%b want 0/%b", cnt1, out_valid,
                  exp_valid());
      else passed++;
      repeat (2) tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 10000; c++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = DW'($urandom);
         out_ready = 3'($urandom);
         cnt_clr   = ($urandom_range(0, 63) == 0);
         #1;
         total++;
         if (in_ready !== exp_ready(in_sel, out_ready))
            $display("FAIL rand_ready cyc=%0d got=%b want=%b", c, in_ready,
                     exp_ready(in_sel, out_ready));
         else passed++;
         total++;
         if (out_valid !== exp_valid())
            $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, out_valid, exp_valid());
         else passed++;
         for (int i = 0; i < 3; i++) begin
            if (mq[i].size() > 0) begin
               total++;
               if (od[i] !== mq[i][0])
                  $display("FAIL rand_data%0d cyc=%0d got=%b want=%b", i, c, od[i], mq[i][0]);
               else passed++;
            end
            total++;
            if (cn[i] !== exp_cnt(i))
               $display("FAIL rand_cnt%0d cyc=%0d got=%0d want=%0d", i, c, cn[i], exp_cnt(i));
            else passed++;
         end
         tick();
      end
      in_valid  = 1'b0;
      cnt_clr   = 1'b0;
      out_ready = 3'b111;
      repeat (3) tick();
   endtask

   task automatic test_async_reset();
      out_ready = 3'b000;
      in_valid  = 1'b1;
      in_sel    = 2'b00;
      in_data   = 2'b01;
      tick();
      in_data = 2'b10;
      tick();
      in_sel  = 2'b10;
      in_data = 2'b11;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 3'b101) $display("FAIL arst_pre got=%b want=101", out_valid);
      else passed++;
      #2;
      reset_l = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mq[i].delete();
         mcnt[i] = 0;
      end
      #1;
      total++;
      if (out_valid !== 3'b000 || in_ready !== 1'b0)
         $display("FAIL arst_valid got valid=%b ready=%b want 000/0", out_valid, in_ready);
      else passed++;
      total++;
      if (cnt0 !== 4'd0 || cnt1 !== 4'd0 || cnt2 !== 4'd0)
         $display("FAIL arst_cnt got=%0d/%0d/%0d want=0/0/0", cnt0, cnt1, cnt2);
      else passed++;
      @(negedge clk);
      reset_l  = 1'b1;
      in_valid = 1'b1;
      in_sel   = 2'b01;
      in_data  = 2'b10;
      #1;
      total++;
      if (in_ready !== 1'b1) $display("FAIL arst_post_ready got=%b want=1", in_ready);
      else passed++;
      tick();
      in_valid = 1'b0;
      #1;
      total++;
      if (out_valid !== 3'b010 || out_data1 !== 2'b10 || cnt1 !== 4'd1)
         $display("FAIL arst_post got valid=%b data1=%b cnt1=%0d want 010/10/1", out_valid,
                  out_data1, cnt1);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_independence();
      test_wrap_clear();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
